// File: rtl/semi_motion_exec.sv
// semi_motion_exec: registered semi-auto motion executor.
// Passes the decision logic's proposed state/move through a register, times
// out turns (200 ticks, 400 ticks for a U-turn), and decodes motors and lights
// from the registered move.
// Optional build macro SEMI_TURN_BLINK_EN: when defined, the active turn light
// blinks with a 25-tick half period; when undefined it is lit steadily.
module semi_motion_exec (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       power,
  input  logic [1:0] global_state,
  input  logic       tick_20ms,
  input  logic [1:0] next_state,
  input  logic [3:0] next_moving_state,
  input  logic       go_back,
  output logic [1:0] state,
  output logic [3:0] moving_state,
  output logic [1:0] mot_l,
  output logic [1:0] mot_r,
  output logic       move_forward_light,
  output logic       move_backward_light,
  output logic       turn_left_light,
  output logic       turn_right_light,
  output logic       turn_done
);

  typedef enum logic [1:0] {
    S1_FWD  = 2'b00,
    S2_WAIT = 2'b01,
    S3_TURN = 2'b10,
    S4_COOL = 2'b11
  } state_t;

  typedef enum logic [3:0] {
    MV_STOP  = 4'b0000,
    MV_FWD   = 4'b0001,
    MV_BACK  = 4'b0010,
    MV_LEFT  = 4'b0100,
    MV_RIGHT = 4'b1000
  } move_t;

  state_t      r_state;
  logic [3:0]  r_move;
  logic        r_turn_done;
  logic [10:0] r_turn_cnt;
  logic        r_around;

  state_t      w_state_nxt;
  logic [3:0]  w_move_nxt;
  logic        w_active;
  logic        w_limit_hit;
  logic        w_timeout;
  logic        w_turn_entry;
  logic        w_blink_on;

  // Next-state selection: inactive mode, then turn timeout, then pass-through.
  always_comb begin
    w_state_nxt  = r_state;
    w_move_nxt   = r_move;
    w_active     = power && ((global_state == 2'b01) || (global_state == 2'b10));
    w_limit_hit  = r_around ? (r_turn_cnt >= 11'd400) : (r_turn_cnt >= 11'd200);
    w_timeout    = w_active && (r_state == S3_TURN) && w_limit_hit;
    if (!w_active) begin
      w_state_nxt = S2_WAIT;
      w_move_nxt  = MV_STOP;
    end else if (w_timeout) begin
      w_state_nxt = S2_WAIT;
      w_move_nxt  = MV_STOP;
    end else begin
      w_state_nxt = state_t'(next_state);
      w_move_nxt  = next_moving_state;
    end
    w_turn_entry = (w_state_nxt == S3_TURN) && (r_state != S3_TURN);
  end

  // State/move register; turn_done marks the edge that took the timeout.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_state     <= S2_WAIT;
      r_move      <= MV_STOP;
      r_turn_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_move      <= w_move_nxt;
      r_turn_done <= w_timeout;
    end
  end

  // Turn tick counter (saturating) and U-turn flag latched on turn entry.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_turn_cnt <= '0;
      r_around   <= 1'b0;
    end else if (!w_active) begin
      r_turn_cnt <= '0;
      r_around   <= 1'b0;
    end else begin
      if (r_state != S3_TURN)
        r_turn_cnt <= '0;
      else if (tick_20ms && (r_turn_cnt != '1))
        r_turn_cnt <= r_turn_cnt + 11'd1;
      if (w_turn_entry)
        r_around <= go_back;
      else if (w_state_nxt != S3_TURN)
        r_around <= 1'b0;
    end
  end

`ifdef SEMI_TURN_BLINK_EN
  logic [4:0] r_blink_cnt;
  logic       r_blink_phase;

  // Blink phase toggles every 25 ticks while turning; restarts lit on entry.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else if (!w_active || w_turn_entry) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else if ((r_state == S3_TURN) && tick_20ms) begin
      if (r_blink_cnt == 5'd24) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 5'd1;
      end
    end
  end

  assign w_blink_on = r_blink_phase;
`else
  assign w_blink_on = 1'b1;
`endif

  // Motor and light decode straight from the registered move.
  always_comb begin
    mot_l               = 2'b00;
    mot_r               = 2'b00;
    move_forward_light  = 1'b0;
    move_backward_light = 1'b0;
    turn_left_light     = 1'b0;
    turn_right_light    = 1'b0;
    case (r_move)
      MV_FWD: begin
        mot_l              = 2'b10;
        mot_r              = 2'b10;
        move_forward_light = 1'b1;
      end
      MV_BACK: begin
        mot_l               = 2'b01;
        mot_r               = 2'b01;
        move_backward_light = 1'b1;
      end
      MV_LEFT: begin
        mot_l           = 2'b01;
        mot_r           = 2'b10;
        turn_left_light = w_blink_on;
      end
      MV_RIGHT: begin
        mot_l            = 2'b10;
        mot_r            = 2'b01;
        turn_right_light = w_blink_on;
      end
      default: ;
    endcase
  end

  assign state        = r_state;
  assign moving_state = r_move;
  assign turn_done    = r_turn_done;

endmodule

// File: tb/tb_semi_motion_exec.sv
// Directed bench for semi_motion_exec; expectations depend on
// SEMI_TURN_BLINK_EN for the turn-light pattern.
module tb_semi_motion_exec;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic       power;
  logic [1:0] global_state;
  logic       tick_20ms;
  logic [1:0] next_state;
  logic [3:0] next_moving_state;
  logic       go_back;
  logic [1:0] state;
  logic [3:0] moving_state;
  logic [1:0] mot_l;
  logic [1:0] mot_r;
  logic       move_forward_light;
  logic       move_backward_light;
  logic       turn_left_light;
  logic       turn_right_light;
  logic       turn_done;

  int n_checks = 0;
  int n_errors = 0;

`ifdef SEMI_TURN_BLINK_EN
  localparam logic BLINK = 1'b1;
`else
  localparam logic BLINK = 1'b0;
`endif

  semi_motion_exec dut (
    .sys_clk            (sys_clk),
    .rst                (rst),
    .power              (power),
    .global_state       (global_state),
    .tick_20ms          (tick_20ms),
    .next_state         (next_state),
    .next_moving_state  (next_moving_state),
    .go_back            (go_back),
    .state              (state),
    .moving_state       (moving_state),
    .mot_l              (mot_l),
    .mot_r              (mot_r),
    .move_forward_light (move_forward_light),
    .move_backward_light(move_backward_light),
    .turn_left_light    (turn_left_light),
    .turn_right_light   (turn_right_light),
    .turn_done          (turn_done)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_20ms = 1'b1;
      step();
    end
    tick_20ms = 1'b0;
  endtask

  function automatic logic [31:0] lights();
    return 32'({move_forward_light, move_backward_light, turn_left_light, turn_right_light});
  endfunction

  function automatic logic [31:0] motors();
    return 32'({mot_l, mot_r});
  endfunction

  initial begin
    rst               = 1'b1;
    power             = 1'b0;
    global_state      = 2'b00;
    tick_20ms         = 1'b0;
    next_state        = 2'b00;
    next_moving_state = 4'b0000;
    go_back           = 1'b0;
    #2;
    chk("reset_state", 32'(state), 32'h1);
    chk("reset_move", 32'(moving_state), 32'h0);
    chk("reset_motors", motors(), 32'h0);
    chk("reset_lights", lights(), 32'h0);
    chk("reset_done", 32'(turn_done), 32'h0);

    // Pass-through forward
    step();
    rst = 1'b0; power = 1'b1; global_state = 2'b01;
    next_state = 2'b00; next_moving_state = 4'b0001;
    step();
    chk("fwd_state", 32'(state), 32'h0);
    chk("fwd_motors", motors(), 32'hA);
    chk("fwd_lights", lights(), 32'h8);

    // Backward, mode 10, state s4 passes through
    global_state = 2'b10; next_state = 2'b11; next_moving_state = 4'b0010;
    step();
    chk("back_state", 32'(state), 32'h3);
    chk("back_motors", motors(), 32'h5);
    chk("back_lights", lights(), 32'h4);

    // Illegal move code
    next_moving_state = 4'b0011;
    step();
    chk("illegal_move", 32'(moving_state), 32'h3);
    chk("illegal_motors", motors(), 32'h0);
    chk("illegal_lights", lights(), 32'h0);

    // Inactive mode 11 overrides next_*
    global_state = 2'b11; next_state = 2'b00; next_moving_state = 4'b0001;
    step();
    chk("inactive_state", 32'(state), 32'h1);
    chk("inactive_move", 32'(moving_state), 32'h0);
    global_state = 2'b01;

    // Left turn, no U-turn
    next_state = 2'b10; next_moving_state = 4'b0100; go_back = 1'b0;
    step();
    chk("left_state", 32'(state), 32'h2);
    chk("left_motors", motors(), 32'h6);
    chk("left_light_t0", lights(), 32'h2);
    ticks(24);
    chk("left_light_t24", lights(), 32'h2);
    ticks(1);
    chk("left_light_t25", lights(), BLINK ? 32'h0 : 32'h2);
    ticks(24);
    chk("left_light_t49", lights(), BLINK ? 32'h0 : 32'h2);
    ticks(1);
    chk("left_light_t50", lights(), 32'h2);
    ticks(149);
    chk("left_t199_state", 32'(state), 32'h2);
    chk("left_t199_done", 32'(turn_done), 32'h0);
    ticks(1);
    chk("left_t200_state", 32'(state), 32'h2);
    step();
    chk("left_timeout_state", 32'(state), 32'h1);
    chk("left_timeout_move", 32'(moving_state), 32'h0);
    chk("left_timeout_done", 32'(turn_done), 32'h1);
    next_state = 2'b01; next_moving_state = 4'b0000;
    step();
    chk("left_done_pulse_end", 32'(turn_done), 32'h0);

    // U-turn right
    next_state = 2'b10; next_moving_state = 4'b1000; go_back = 1'b1;
    step();
    go_back = 1'b0;
    chk("uturn_state", 32'(state), 32'h2);
    chk("uturn_motors", motors(), 32'h9);
    ticks(200);
    step();
    chk("uturn_t200_state", 32'(state), 32'h2);
    chk("uturn_t200_done", 32'(turn_done), 32'h0);
    chk("uturn_t200_motors", motors(), 32'h9);
    chk("uturn_t200_light", lights(), 32'h1);
    ticks(199);
    step();
    chk("uturn_t399_state", 32'(state), 32'h2);
    ticks(1);
    step();
    chk("uturn_timeout_state", 32'(state), 32'h1);
    chk("uturn_timeout_done", 32'(turn_done), 32'h1);
    chk("uturn_timeout_motors", motors(), 32'h0);
    next_state = 2'b01; next_moving_state = 4'b0000;
    step();

    // Power drop mid-turn, then a fresh turn
    next_state = 2'b10; next_moving_state = 4'b0100;
    step();
    ticks(150);
    power = 1'b0;
    step();
    chk("pdrop_state", 32'(state), 32'h1);
    chk("pdrop_move", 32'(moving_state), 32'h0);
    chk("pdrop_done", 32'(turn_done), 32'h0);
    power = 1'b1;
    step();
    chk("pdrop_reenter", 32'(state), 32'h2);
    ticks(199);
    step();
    chk("pdrop_t199_state", 32'(state), 32'h2);
    ticks(1);
    step();
    chk("pdrop_timeout_done", 32'(turn_done), 32'h1);
    next_state = 2'b01; next_moving_state = 4'b0000;
    step();

    // Asynchronous reset mid-turn
    next_state = 2'b10; next_moving_state = 4'b0100;
    step();
    ticks(100);
    rst = 1'b1;
    #1;
    chk("arst_state", 32'(state), 32'h1);
    chk("arst_move", 32'(moving_state), 32'h0);
    chk("arst_motors", motors(), 32'h0);
    chk("arst_lights", lights(), 32'h0);
    chk("arst_done", 32'(turn_done), 32'h0);
    #2;
    rst = 1'b0;
    next_state = 2'b00; next_moving_state = 4'b0001;
    step();
    chk("arst_resume_state", 32'(state), 32'h0);
    chk("arst_resume_motors", motors(), 32'hA);
    next_state = 2'b10; next_moving_state = 4'b0100;
    step();
    ticks(199);
    step();
    chk("arst_fresh_t199", 32'(state), 32'h2);
    ticks(1);
    step();
    chk("arst_fresh_timeout", 32'(state), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
